// File: rtl/aes444_decrypt.sv
// aes444_decrypt
//   Iterative Small Scale AES SR(ROUNDS,4,4,4) decryption core. The cipher
//   key K0 is expanded forward to K_ROUNDS, the ciphertext is whitened with
//   it, and the inverse rounds then run one per cycle while the key schedule
//   is unwound one step per cycle back towards K0.
//
//   Ports
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     start     request; sampled only while idle (latches key_in / text_in)
//     key_in    64-bit cipher key K0 (same value given to the encryptor)
//     text_in   64-bit ciphertext
//     text_out  64-bit plaintext, valid from the done cycle onwards
//     busy      high while an operation is in progress
//     done      one-cycle pulse when text_out is updated
//
//   Nibble i lives in bits [63-4i -: 4]; state[r][c] is nibble 4c+r.
module aes444_decrypt #(
    parameter int ROUNDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic [63:0] text_in,
    output logic [63:0] text_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, KEXP, ADDK, ROUND} fsm_t;

    fsm_t        fsm, fsm_nxt;
    logic [63:0] st;
    logic [63:0] key;
    logic [3:0]  cnt;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        case (n)
            4'h0: sbox = 4'h6; 4'h1: sbox = 4'hB; 4'h2: sbox = 4'h5; 4'h3: sbox = 4'h4;
            4'h4: sbox = 4'h2; 4'h5: sbox = 4'hE; 4'h6: sbox = 4'h7; 4'h7: sbox = 4'hA;
            4'h8: sbox = 4'h9; 4'h9: sbox = 4'hD; 4'hA: sbox = 4'hF; 4'hB: sbox = 4'hC;
            4'hC: sbox = 4'h3; 4'hD: sbox = 4'h1; 4'hE: sbox = 4'h0; default: sbox = 4'h8;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        case (n)
            4'h0: inv_sbox = 4'hE; 4'h1: inv_sbox = 4'hD; 4'h2: inv_sbox = 4'h4; 4'h3: inv_sbox = 4'hC;
            4'h4: inv_sbox = 4'h3; 4'h5: inv_sbox = 4'h2; 4'h6: inv_sbox = 4'h0; 4'h7: inv_sbox = 4'h6;
            4'h8: inv_sbox = 4'hF; 4'h9: inv_sbox = 4'h8; 4'hA: inv_sbox = 4'h7; 4'hB: inv_sbox = 4'h1;
            4'hC: inv_sbox = 4'hB; 4'hD: inv_sbox = 4'h9; 4'hE: inv_sbox = 4'h5; default: inv_sbox = 4'hA;
        endcase
    endfunction

    function automatic logic [3:0] rcon(input logic [3:0] i);
        case (i)
            4'd1: rcon = 4'h1; 4'd2: rcon = 4'h2; 4'd3: rcon = 4'h4; 4'd4: rcon = 4'h8;
            4'd5: rcon = 4'h3; 4'd6: rcon = 4'h6; 4'd7: rcon = 4'hC; 4'd8: rcon = 4'hB;
            4'd9: rcon = 4'h5; 4'd10: rcon = 4'hA; default: rcon = 4'h0;
        endcase
    endfunction

    // GF(2^4) multiply, x^4 = x + 1
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] x;
        acc = 4'h0;
        x   = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        gmul = acc;
    endfunction

    // Sub(Rot(w)) with Rcon folded into the top nibble
    function automatic logic [15:0] sub_rot(input logic [15:0] w, input logic [3:0] rc);
        sub_rot = {sbox(w[11:8]) ^ rc, sbox(w[7:4]), sbox(w[3:0]), sbox(w[15:12])};
    endfunction

    function automatic logic [63:0] key_fwd(input logic [63:0] k, input logic [3:0] rc);
        logic [15:0] w0, w1, w2, w3;
        w0 = k[63:48] ^ sub_rot(k[15:0], rc);
        w1 = k[47:32] ^ w0;
        w2 = k[31:16] ^ w1;
        w3 = k[15:0]  ^ w2;
        key_fwd = {w0, w1, w2, w3};
    endfunction

    // Undo one forward step: w3 must be recovered before w0 can be
    function automatic logic [63:0] key_inv(input logic [63:0] k, input logic [3:0] rc);
        logic [15:0] w0, w1, w2, w3;
        w3 = k[15:0]  ^ k[31:16];
        w2 = k[31:16] ^ k[47:32];
        w1 = k[47:32] ^ k[63:48];
        w0 = k[63:48] ^ sub_rot(w3, rc);
        key_inv = {w0, w1, w2, w3};
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless last
    function automatic logic [63:0] inv_round(input logic [63:0] s, input logic [63:0] rk,
                                              input logic last);
        logic [63:0] t;
        logic [63:0] m;
        t = '0;
        m = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[63-4*(4*c+r) -: 4] = inv_sbox(s[63-4*(4*((c-r+4)%4)+r) -: 4]);
        t = t ^ rk;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[63-4*(4*c+r) -: 4] = gmul(4'hE, t[63-4*(4*c+r)         -: 4]) ^
                                       gmul(4'hB, t[63-4*(4*c+(r+1)%4)   -: 4]) ^
                                       gmul(4'hD, t[63-4*(4*c+(r+2)%4)   -: 4]) ^
                                       gmul(4'h9, t[63-4*(4*c+(r+3)%4)   -: 4]);
        inv_round = last ? t : m;
    endfunction

    // During KEXP cnt counts up and step cnt+1 is applied; during ROUND cnt
    // counts down and key holds K(cnt+1), so both steps use Rcon(cnt+1).
    logic [3:0]  rc_idx;
    logic [63:0] key_next;
    logic [63:0] key_prev;
    logic [63:0] round_out;
    logic        last_round;

    assign rc_idx     = cnt + 4'd1;
    assign key_next   = key_fwd(key, rcon(rc_idx));
    assign key_prev   = key_inv(key, rcon(rc_idx));
    assign last_round = (cnt == 4'd0);
    assign round_out  = inv_round(st, key_prev, last_round);
    assign busy       = (fsm != IDLE);

    always_ff @(posedge clk) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (start) fsm_nxt = KEXP;
            KEXP:    if (cnt == 4'(ROUNDS - 1)) fsm_nxt = ADDK;
            ADDK:    fsm_nxt = ROUND;
            ROUND:   if (last_round) fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= '0;
            key      <= '0;
            cnt      <= '0;
            text_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        st  <= text_in;
                        key <= key_in;
                        cnt <= '0;
                    end
                end
                KEXP: begin
                    key <= key_next;
                    cnt <= cnt + 4'd1;
                end
                ADDK: begin
                    st  <= st ^ key;
                    cnt <= 4'(ROUNDS - 1);
                end
                ROUND: begin
                    st  <= round_out;
                    key <= key_prev;
                    if (last_round) begin
                        text_out <= round_out;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes444_decrypt.sv
module tb_aes444_decrypt;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic [63:0] text_in;
    logic [63:0] text_out;
    logic        busy;
    logic        done;

    int n_pass = 0;
    int n_chk  = 0;

    aes444_decrypt #(.ROUNDS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .text_in(text_in),
        .text_out(text_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] SB [16] = '{4'h6, 4'hB, 4'h5, 4'h4, 4'h2, 4'hE, 4'h7, 4'hA,
                                       4'h9, 4'hD, 4'hF, 4'hC, 4'h3, 4'h1, 4'h0, 4'h8};
    localparam logic [3:0] RC [11] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC,
                                       4'hB, 4'h5, 4'hA};

    // ---------------- reference encryptor (AES444) ----------------
    // polynomial product then reduction by x^4+x+1 (0x13)
    function automatic logic [3:0] gf(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ ({4'h0, a} << i);
        for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
        return p[3:0];
    endfunction

    function automatic logic [3:0] nib(input logic [63:0] s, input int idx);
        return s[63-4*idx -: 4];
    endfunction

    function automatic logic [63:0] kstep(input logic [63:0] k, input int i);
        logic [15:0] w [4];
        logic [15:0] t;
        for (int j = 0; j < 4; j++) w[j] = k[63-16*j -: 16];
        t = {SB[w[3][11:8]] ^ RC[i], SB[w[3][7:4]], SB[w[3][3:0]], SB[w[3][15:12]]};
        w[0] = w[0] ^ t;
        for (int j = 1; j < 4; j++) w[j] = w[j] ^ w[j-1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [63:0] aes_enc(input logic [63:0] k, input logic [63:0] p);
        logic [63:0] rk [11];
        logic [63:0] s, o;
        logic [3:0]  a [4];
        rk[0] = k;
        for (int i = 1; i <= 10; i++) rk[i] = kstep(rk[i-1], i);
        s = p ^ rk[0];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            o = '0;
            for (int c = 0; c < 4; c++)          // SubBytes + ShiftRows (row r left by r)
                for (int r = 0; r < 4; r++)
                    o[63-4*(4*c+r) -: 4] = SB[nib(s, 4*((c+r)%4)+r)];
            s = o;
            if (rnd != 10) begin                 // MixColumns (2,3,1,1)
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = nib(s, 4*c+r);
                    for (int r = 0; r < 4; r++)
                        o[63-4*(4*c+r) -: 4] = gf(4'h2, a[r]) ^ gf(4'h3, a[(r+1)%4]) ^
                                               a[(r+2)%4] ^ a[(r+3)%4];
                end
                s = o;
            end
            s = s ^ rk[rnd];
        end
        return s;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Encrypt p with the model, decrypt on the DUT, check result/latency/pulse.
    task automatic run_op(input string name, input logic [63:0] k, input logic [63:0] p);
        int cyc;
        key_in  = k;
        text_in = aes_enc(k, p);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        key_in  = {$urandom, $urandom};  // must not disturb the latched operation
        text_in = {$urandom, $urandom};
        chk({name, "_busy"}, 64'(busy), 64'd1);
        wait_done(cyc);
        chk({name, "_text"}, text_out, p);
        chk({name, "_lat"}, 64'(cyc), 64'd21);
        @(negedge clk);
        chk({name, "_done_once"}, 64'(done), 64'd0);
    endtask

    typedef struct {
        logic [63:0] key;
        logic [63:0] pt;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          cyc;
        logic [63:0] ka, pa, kb, pb;
        logic        hold_ok;

        tbl[0] = '{64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
        tbl[1] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[3] = '{64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D};
        tbl[4] = '{64'h8000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001};
        tbl[5] = '{64'h5A5A_A5A5_3C3C_C3C3, 64'h1111_2222_4444_8888, 64'h1111_2222_4444_8888};

        // Reset held with start high
        rst = 1'b1; start = 1'b1; key_in = 64'h1234; text_in = 64'h5678;
        repeat (2) @(negedge clk);
        chk("rst_text", text_out, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_no_op", 64'(busy), 64'd0);

        // Directed table, first entry is the FEDC.. / zero round trip
        for (int i = 0; i < 6; i++) begin
            key_in  = tbl[i].key;
            text_in = aes_enc(tbl[i].key, tbl[i].pt);
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
            wait_done(cyc);
            chk($sformatf("tbl%0d_text", i), text_out, tbl[i].exp);
            chk($sformatf("tbl%0d_lat", i), 64'(cyc), 64'd21);
            @(negedge clk);
        end

        // Random sweep
        for (int i = 0; i < 200; i++)
            run_op($sformatf("rnd%0d", i), {$urandom, $urandom}, {$urandom, $urandom});

        // Busy guard: extra starts at cycles 5 and 15
        ka = {$urandom, $urandom}; pa = {$urandom, $urandom};
        key_in = ka; text_in = aes_enc(ka, pa); start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (cyc == 5 || cyc == 15) begin
                start = 1'b1; key_in = {$urandom, $urandom}; text_in = {$urandom, $urandom};
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("guard_text", text_out, pa);
        chk("guard_lat", 64'(cyc), 64'd21);
        @(negedge clk);

        // Mid-operation reset at edge 8, then restart
        key_in = {$urandom, $urandom}; text_in = {$urandom, $urandom}; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_text", text_out, 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        run_op("mrst_restart", 64'hA5A5_0F0F_F0F0_5A5A, 64'h0123_4567_89AB_CDEF);

        // Back-to-back: second start in the done cycle
        ka = {$urandom, $urandom}; pa = {$urandom, $urandom};
        kb = {$urandom, $urandom}; pb = ~pa;
        key_in = ka; text_in = aes_enc(ka, pa); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("b2b_first", text_out, pa);
        chk("b2b_first_done", 64'(done), 64'd1);
        key_in = kb; text_in = aes_enc(kb, pb); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        hold_ok = 1'b1; cyc = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (text_out !== pa) hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk("b2b_hold", 64'(hold_ok), 64'd1);
        chk("b2b_second", text_out, pb);
        chk("b2b_lat", 64'(cyc), 64'd21);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes444_decrypt.md
# aes444_decrypt

Iterative Small Scale AES SR(10,4,4,4) decryption core: the inverse of the AES444 encryption core, sharing its 64-bit block/key format, S-box, MixColumns field and key schedule. It accepts a 64-bit ciphertext and the original cipher key, expands the key forward to the last round key, then runs the ten inverse rounds one per cycle while unwinding the key schedule backwards. It sits beside AES444 in the small-scale AES datapath and closes the encrypt/decrypt loop for verification and fault experiments.

## Interface
- ROUNDS, 10, number of rounds; valid range 1..10, limited by the Rcon table.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  sampled in IDLE only; latches key_in and text_in.
- key_in  in  64  cipher key K0, the same value given to AES444.
- text_in  in  64  ciphertext.
- text_out  out  64  plaintext; valid from the done cycle until the next accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when text_out becomes valid.

## Operation
- Nibble order: nibble i = bits [63-4i : 60-4i]; state[r][c] = nibble 4c+r (column-major). The key uses the same order as four 16-bit words w0..w3.
- GF(2^4) uses the polynomial x^4+x+1.
- S-box, indices 0..F: 6 B 5 4 2 E 7 A 9 D F C 3 1 0 8. Inverse S-box: E D 4 C 3 2 0 6 F 8 7 1 B 9 5 A.
- InvShiftRows: row r is rotated right by r positions.
- InvMixColumns: circulant matrix (E,B,D,9) per column.
- Rcon(1..10): 1 2 4 8 3 6 C B 5 A. It is XORed into the top nibble of the word.
- Forward key step i: t = Sub(Rot(w3)) ^ Rcon(i); w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Inverse key step i, from K(i) to K(i-1):
  - w3 = w3'^w2'; w2 = w2'^w1'; w1 = w1'^w0';
  - w0 = w0' ^ Sub(Rot(w3)) ^ Rcon(i), where w3 is the value just recovered.
- Decryption sequence:
  - s = C ^ K10.
  - Rounds r = 9 down to 1: InvShiftRows, InvSubBytes, AddRoundKey(Kr), InvMixColumns.
  - Final round: InvShiftRows, InvSubBytes, AddRoundKey(K0).
- FSM states: IDLE, KEXP, ADDK, ROUND.
  - IDLE: on start, latch text and key, clear the round counter, go to KEXP.
  - KEXP: one forward key step per cycle for ROUNDS cycles, then go to ADDK.
  - ADDK: state <= text ^ K_ROUNDS; go to ROUND.
  - ROUND: one inverse round per cycle together with one inverse key step. The counter counts down. On the last round (counter = 0) write text_out, pulse done, return to IDLE.
- The round datapath and the key-step logic are combinational between registers. There is no S-box sharing across cycles.
- start while busy is ignored; latched inputs do not change.
- Changes on key_in or text_in after the start cycle have no effect.

## Timing
- Reset values: text_out = 0, busy = 0, done = 0, FSM in IDLE, internal state, key and counter registers all 0.
- Edge 0 samples start = 1. busy is 1 after edge 0.
- Edges 1..ROUNDS run KEXP. Edge ROUNDS+1 runs ADDK. Edges ROUNDS+2..2·ROUNDS+1 run the rounds.
- For ROUNDS = 10, done = 1 and text_out is valid after edge 21, so the latency is 21 cycles from the start sample.
- busy falls after edge 21, in the same cycle that done is high.
- done lasts exactly one cycle. text_out holds until the edge that accepts the next start, then holds its old value until the next done.
- Back-to-back: a start asserted in the done cycle is accepted, because the FSM is already in IDLE.
- rst asserted in any state takes effect at the next edge: all outputs return to reset values and the operation is abandoned. A start asserted in the same cycle as rst is ignored.

## Test plan
- Reset:
  - hold rst for 2 cycles with start = 1 -> text_out = 0, busy = 0, done = 0, and no operation begins.
- Round trip:
  - encrypt plaintext 0 with key FEDC_BA98_7654_3210 on AES444.
  - feed the resulting ciphertext with the same key -> done after exactly 21 cycles, text_out = 0000_0000_0000_0000.
- Random sweep:
  - 200 random key/plaintext pairs, each encrypted by AES444 then decrypted -> text_out equals the plaintext every time, done pulses once per operation.
- Busy guard:
  - pulse start again at cycles 5 and 15 with different data -> those pulses are ignored, and the result matches the first operation.
- Mid-operation reset:
  - assert rst at cycle 8, then restart with new data -> outputs are zero after reset, and the new result is correct with full latency.
- Back-to-back:
  - assert start in the done cycle -> the second result arrives 21 cycles later, and the first text_out holds until then.
